// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory responder.
// Holds the FSM state encoding, strobe/word geometry and the struct used
// to carry a latched request through the access latency.
package data_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int STRB_W     = 4;
  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 8 * WORD_BYTES;

  // Request fields kept while the access is pending (address held separately
  // because its width is a parameter of the top).
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_fields_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// mem_array: DEPTH x 32-bit word storage.
// Synchronous byte-strobed write, combinational read of the same index.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable for this cycle
//   idx   - word index for both read and write
//   wdata - write data
//   wstrb - byte enables, bit i covers wdata[8i+7:8i]
//   rdata - word currently stored at idx
// Contents are never reset.
module mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core load/store port.
// Accepts one request at a time (valid/ready), waits LATENCY cycles, performs
// the access on a word RAM and presents a response held until rsp_ready.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid / req_ready    - request handshake
//   req_we, req_addr         - store flag, byte address
//   req_wdata, req_wstrb     - store data and byte enables
//   rsp_valid / rsp_ready    - response handshake
//   rsp_rdata, rsp_err       - load data (0 for stores/errors), fault flag
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                LATENCY   = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  req_fields_t       lat;

  logic [ADDR_W-1:0] off, word;
  logic              err_dec;
  logic              accept, access, mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Decode runs on the latched address; it is only consumed at the access cycle.
  // An address below BASE_ADDR wraps to a huge offset and lands out of range.
  assign off     = lat_addr - BASE_ADDR;
  assign word    = off >> 2;
  assign err_dec = (lat_addr[1:0] != 2'b00) || (word >= ADDR_W'(DEPTH));

  assign accept = req_valid && req_ready;
  assign access = (state == ST_WAIT) && (cnt == '0);
  // rst gating keeps a reset that lands on the access edge from committing.
  assign mem_we = access && lat.we && !err_dec && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)      state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == '0)   state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state == ST_IDLE) && !rst;
    rsp_valid = (state == ST_RESP);
  end

  // Counter, request latch and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr <= req_addr;
        lat      <= '{we: req_we, wdata: req_wdata, wstrb: req_wstrb};
        cnt      <= CNT_W'(LATENCY - 1);
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        rsp_err   <= err_dec;
        rsp_rdata <= (!lat.we && !err_dec) ? mem_rdata : '0;
      end
    end
  end

  mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (word[IDX_W-1:0]),
    .wdata (lat.wdata),
    .wstrb (lat.wstrb),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) share clk/rst.
// Expected responses come from a word-level model and go through a queue.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]  req_wstrb;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  exp_t        sbq[$];
  logic [31:0] model[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_responder #(
      .ADDR_W(32), .DEPTH(256), .LATENCY(g == 0 ? 2 : 1), .BASE_ADDR(32'h0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wstrb (req_wstrb[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Reference behaviour: DEPTH 256, BASE 0.
  function automatic exp_t model_exp(input int d, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] strb);
    exp_t e;
    int   k;
    logic [31:0] w;
    e.err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
    e.rdata = 32'h0;
    k = d * 1024 + int'(addr >> 2);
    if (!e.err) begin
      w = model.exists(k) ? model[k] : 32'h0;
      if (we) begin
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        model[k] = w;
      end else begin
        e.rdata = w;
      end
    end
    return e;
  endfunction

  // Called at a negedge. Returns at a negedge: IDLE when hold=0, or at the
  // response cycle with req_valid still high when hold=1.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input bit hold, output int acc);
    exp_t e;
    int   n;
    sbq.push_back(model_exp(d, we, addr, wdata, strb));
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_wstrb[d] = strb;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tests_run++;
    acc = -1;
    if (req_ready[d] !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout dut%0d addr=%h req_ready=%b want 1", d, addr, req_ready[d]);
      req_valid[d] = 1'b0; void'(sbq.pop_back());
      return;
    end
    acc = cyc + 1;
    @(negedge clk);
    if (!hold) req_valid[d] = 1'b0;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (rsp_valid[d] !== 1'b1) begin
      fails++;
      $display("FAIL rsp_timeout dut%0d addr=%h rsp_valid=%b want 1", d, addr, rsp_valid[d]);
      void'(sbq.pop_back());
      return;
    end
    tests_run++;
    if (cyc - acc !== lat_of(d)) begin
      fails++;
      $display("FAIL latency dut%0d addr=%h got %0d want %0d", d, addr, cyc - acc, lat_of(d));
    end
    e = sbq.pop_front();
    tests_run++;
    if (rsp_rdata[d] !== e.rdata || rsp_err[d] !== e.err) begin
      fails++;
      $display("FAIL rsp_data dut%0d addr=%h we=%b got rdata=%h err=%b want rdata=%h err=%b",
               d, addr, we, rsp_rdata[d], rsp_err[d], e.rdata, e.err);
    end
    if (!hold) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    tests_run++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      fails++;
      $display("FAIL reset_hs req_ready=%b rsp_valid=%b want 00 00", req_ready, rsp_valid);
    end
    tests_run++;
    if (rsp_rdata !== '0 || rsp_err !== 2'b00) begin
      fails++;
      $display("FAIL reset_rsp rdata=%h err=%b want 0 0", rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 2'b11) begin
      fails++;
      $display("FAIL reset_release req_ready=%b want 11", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int a;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, a);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, a);
  endtask

  task automatic test_strobe();
    int a;
    txn(0, 1'b1, 32'h10, 32'h0000CAFE, 4'h3, 1'b0, a);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, a);      // wstrb ignored on loads
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, a);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, a);
    txn(0, 1'b1, 32'h14, 32'h01020304, 4'hF, 1'b0, a);
    txn(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'h9, 1'b0, a);
    txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, a);
  endtask

  task automatic test_errors();
    int a;
    txn(0, 1'b1, 32'h20,  32'h11111111, 4'hF, 1'b0, a);
    txn(0, 1'b1, 32'h3FC, 32'h12345678, 4'hF, 1'b0, a);  // last word in range
    txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, a);
    txn(0, 1'b0, 32'h12,  32'h0, 4'h0, 1'b0, a);         // misaligned
    txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, a);         // out of range
    txn(0, 1'b1, 32'h400, 32'hCCCCCCCC, 4'hF, 1'b0, a);
    txn(0, 1'b1, 32'h13,  32'hCCCCCCCC, 4'hF, 1'b0, a);
    txn(0, 1'b1, 32'hFFFFFFF0, 32'hCCCCCCCC, 4'hF, 1'b0, a);
    txn(0, 1'b0, 32'h10,  32'h0, 4'h0, 1'b0, a);
    txn(0, 1'b0, 32'h20,  32'h0, 4'h0, 1'b0, a);
    txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, a);
    txn(0, 1'b0, 32'h0,   32'h0, 4'h0, 1'b0, a);   // word 0 of 0x400 alias
  endtask

  task automatic test_backpressure();
    exp_t e, e2;
    int   n, acc, h;
    bit   ok;
    rsp_ready[0] = 1'b0;
    sbq.push_back(model_exp(0, 1'b0, 32'h10, 32'h0, 4'h0));
    req_we[0] = 1'b0; req_addr[0] = 32'h10; req_wstrb[0] = 4'h0; req_valid[0] = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    acc = cyc + 1;
    @(negedge clk);
    req_addr[0] = 32'h20;   // new request held high throughout
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (cyc - acc !== 2) begin
      fails++;
      $display("FAIL bp_latency got %0d want 2", cyc - acc);
    end
    e = sbq.pop_front();
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err ||
          req_ready[0] !== 1'b0) begin
        ok = 1'b0;
        $display("FAIL bp_hold k=%0d valid=%b rdata=%h err=%b req_ready=%b want 1 %h %b 0",
                 k, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], e.rdata, e.err);
      end
      if (k < 5) @(negedge clk);
    end
    tests_run++;
    if (!ok) fails++;
    rsp_ready[0] = 1'b1;
    h = cyc + 1;
    sbq.push_back(model_exp(0, 1'b0, 32'h20, 32'h0, 4'h0));
    @(negedge clk);
    tests_run++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release rsp_valid=%b req_ready=%b want 0 1", rsp_valid[0], req_ready[0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (rsp_valid[0] !== 1'b1 || cyc !== h + 3) begin
      fails++;
      $display("FAIL bp_second_timing rsp_valid=%b edge=%0d want 1 %0d", rsp_valid[0], cyc, h + 3);
    end
    e2 = sbq.pop_front();
    tests_run++;
    if (rsp_rdata[0] !== e2.rdata || rsp_err[0] !== e2.err) begin
      fails++;
      $display("FAIL bp_second_data got %h %b want %h %b", rsp_rdata[0], rsp_err[0], e2.rdata, e2.err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int  n, a;
    bit  ok;
    req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h22222222; req_wstrb[0] = 4'hF;
    req_valid[0] = 1'b1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);          // counter now 0: next edge would commit the write
    rst = 1'b1;
    #1;
    tests_run++;
    if (req_ready[0] !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_ready_in_rst req_ready=%b want 0", req_ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready[0] !== 1'b1 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_after req_ready=%b rdata=%h err=%b want 1 0 0",
               req_ready[0], rsp_rdata[0], rsp_err[0]);
    end
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid[0] !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL rstmid_no_rsp rsp_valid rose, want 0");
    end
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, a);   // model still holds 0x11111111
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    txn(1, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 1'b0, a0);
    txn(1, 1'b1, 32'h4, 32'h5A5A5A5A, 4'hF, 1'b0, a0);
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a0);
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, a1);
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, a2);
    tests_run++;
    if (a1 - a0 !== 3 || a2 - a1 !== 3) begin
      fails++;
      $display("FAIL b2b_spacing got %0d %0d want 3 3", a1 - a0, a2 - a1);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_strobe();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog bench did not complete, tests=%0d fails=%0d", tests_run, fails);
    $fatal(1);
  end

endmodule
